// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Brief    : Shared constants and helpers for the instruction-fetch stage
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    // Fetch FSM state encoding
    localparam logic [0:0]  c_IF_FETCH       = 1'b0;
    localparam logic [0:0]  c_IF_DONE        = 1'b1;

    // Instruction geometry: four bytes per 32-bit word
    localparam logic [2:0]  c_BYTES_PER_INST = 3'd4;
    localparam logic [31:0] c_INST_STRIDE    = 32'd4;
    localparam logic [31:0] c_ZERO_WORD      = 32'h0000_0000;

    // True while another byte of the current word still has to be requested
    function automatic logic idx_issuable(input logic [2:0] idx);
        return (idx < c_BYTES_PER_INST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_byte_asm.sv
`default_nettype none
// ============================================================================
// Module   : if_byte_asm
// Brief    : Byte issue counter and little-endian word assembler for IF
// Revision : 1.0 - initial release
// ============================================================================
module if_byte_asm
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_clear,
    input  logic        i_issue,
    input  logic [7:0]  i_din,
    output logic [2:0]  o_idx,
    output logic        o_done,
    output logic [31:0] o_word
);

    logic [2:0]  r_idx;
    logic        r_pend;
    logic [23:0] r_buf;

    // Byte 3 arrives when a read is pending and all four have been issued
    logic        w_last_byte;
    assign w_last_byte = r_pend && (r_idx == c_BYTES_PER_INST);

    // Track issued bytes and shift returning bytes 0..2 into the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 3'd0;
            r_pend <= 1'b0;
            r_buf  <= 24'h00_0000;
        end else if (i_en) begin
            if (i_clear) begin
                r_idx  <= 3'd0;
                r_pend <= 1'b0;
            end else begin
                r_pend <= i_issue;
                if (i_issue) begin
                    r_idx <= r_idx + 3'd1;
                end
                if (r_pend && !w_last_byte) begin
                    r_buf <= {i_din, r_buf[23:8]};
                end
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_done = w_last_byte;
    assign o_word = {i_din, r_buf};

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch over a byte-wide shared RAM port; holds pc,
//            fetch/done state and EX redirects, delivers IF/ID pc and word
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 17,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        stall,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic              stall_req
);

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic [2:0]  w_idx;
    logic        w_done;
    logic [31:0] w_word;
    logic        w_fetching;
    logic        w_issue;
    logic        w_restart;
    logic        w_clear;
    logic        w_stall_unused;

    // Only the IF hold bit matters to this stage
    assign w_stall_unused = |stall[4:1];

    assign w_fetching = (r_state == c_IF_FETCH);
    assign w_restart  = (r_state == c_IF_DONE) && !stall[0];
    assign w_clear    = branch_flag || w_restart;

    // A redirect cycle issues nothing so no stale byte is requested
    assign mem_rd   = rdy && w_fetching && idx_issuable(w_idx) && !branch_flag;
    assign mem_addr = r_pc[ADDR_W-1:0] + {{(ADDR_W-3){1'b0}}, w_idx};
    assign w_issue  = mem_rd && mem_gnt;

    if_byte_asm u_byte_asm (
        .clk     (clk),
        .rst     (rst),
        .i_en    (rdy),
        .i_clear (w_clear),
        .i_issue (w_issue),
        .i_din   (mem_din),
        .o_idx   (w_idx),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    // pc / state sequencing with redirect taking priority over delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_state   <= c_IF_FETCH;
            r_if_pc   <= c_ZERO_WORD;
            r_if_inst <= c_ZERO_WORD;
        end else if (rdy) begin
            if (branch_flag) begin
                r_pc    <= branch_target;
                r_state <= c_IF_FETCH;
            end else if (r_state == c_IF_FETCH) begin
                if (w_done) begin
                    r_if_inst <= w_word;
                    r_if_pc   <= r_pc;
                    r_state   <= c_IF_DONE;
                end
            end else if (!stall[0]) begin
                r_pc    <= r_pc + c_INST_STRIDE;
                r_state <= c_IF_FETCH;
            end
        end
    end

    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;
    assign stall_req = w_fetching;

endmodule
`default_nettype wire
